// File: rtl/frame_streamer_if.sv
// Frame-streamer bundle: start/pause control, frame-memory read port and pixel stream.
// master is the streamer side; slave is the memory/consumer side.
interface frame_streamer_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              start_in;
  logic              pause_in;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [7:0]        rd_data_in;
  logic              data_valid_out;
  logic [7:0]        pixel_data_out;
  logic [10:0]       hcount_out;
  logic [9:0]        vcount_out;
  logic              busy_out;
  logic              frame_done_out;

  modport master (
    input  start_in, pause_in, rd_data_in,
    output rd_addr_out, data_valid_out, pixel_data_out, hcount_out, vcount_out,
    output busy_out, frame_done_out
  );

  modport slave (
    output start_in, pause_in, rd_data_in,
    input  rd_addr_out, data_valid_out, pixel_data_out, hcount_out, vcount_out,
    input  busy_out, frame_done_out
  );
endinterface

// File: rtl/frame_streamer.sv
// Streams one raster-ordered frame out of a fixed-latency frame memory per start request.
// Coordinates ride a token pipe matched to the memory latency so they line up with the data.
module frame_streamer #(
  parameter int unsigned HRES       = 180,
  parameter int unsigned VRES       = 320,
  parameter int unsigned RD_LATENCY = 2
) (
  input logic              clk_in,
  input logic              rst_in,
  frame_streamer_if.master bus
);
  localparam int unsigned ADDR_W = $clog2(HRES * VRES);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [10:0] HLast = 11'(HRES - 1);
  localparam logic [9:0]  VLast = 10'(VRES - 1);

  logic [1:0]        state_q, state_d;
  logic [10:0]       h_q, h_d;
  logic [9:0]        v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tok_valid;

  logic [RD_LATENCY-1:0]       pv_q;
  logic [RD_LATENCY-1:0][10:0] ph_q;
  logic [RD_LATENCY-1:0][9:0]  pvv_q;

  logic        out_valid;
  logic [10:0] out_h;
  logic [9:0]  out_v;
  logic        last_issue;
  logic        frame_done;

  assign out_valid  = pv_q[RD_LATENCY-1];
  assign out_h      = ph_q[RD_LATENCY-1];
  assign out_v      = pvv_q[RD_LATENCY-1];
  assign last_issue = (h_q == HLast) && (v_q == VLast);
  assign frame_done = out_valid && (out_h == HLast) && (out_v == VLast);

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    v_d       = v_q;
    addr_d    = addr_q;
    tok_valid = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          state_d = StIssue;
          h_d     = '0;
          v_d     = '0;
          addr_d  = '0;
        end
      end
      StIssue: begin
        if (!bus.pause_in) begin
          tok_valid = 1'b1;
          // Counters stop on the final pixel so the address bus holds its last value.
          if (last_issue) begin
            state_d = StDrain;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            if (h_q == HLast) begin
              h_d = '0;
              v_d = v_q + 10'd1;
            end else begin
              h_d = h_q + 11'd1;
            end
          end
        end
      end
      StDrain: begin
        if (frame_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= '0;
      pv_q    <= '0;
      ph_q    <= '0;
      pvv_q   <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pv_q[i]  <= pv_q[i-1];
        ph_q[i]  <= ph_q[i-1];
        pvv_q[i] <= pvv_q[i-1];
      end
      pv_q[0]  <= tok_valid;
      ph_q[0]  <= h_q;
      pvv_q[0] <= v_q;
    end
  end

  assign bus.rd_addr_out    = addr_q;
  assign bus.data_valid_out = out_valid;
  // Gate the memory data so the pixel bus never shows X between pixels.
  assign bus.pixel_data_out = out_valid ? bus.rd_data_in : 8'd0;
  assign bus.hcount_out     = out_h;
  assign bus.vcount_out     = out_v;
  assign bus.busy_out       = (state_q != StIdle);
  assign bus.frame_done_out = frame_done;
endmodule

// File: tb/tb_frame_streamer.sv
// Self-checking bench for frame_streamer on a 4x3 frame with a 2-cycle memory returning its address.
module tb_frame_streamer;
  localparam int unsigned HRES = 4;
  localparam int unsigned VRES = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned NPIX = HRES * VRES;
  localparam int unsigned AW   = $clog2(HRES * VRES);

  typedef struct {
    logic [7:0]  data;
    logic [10:0] h;
    logic [9:0]  v;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned busy_cnt = 0;
  int unsigned fd_cnt = 0;
  int unsigned vlog[$];
  exp_t q[$];
  exp_t mon_e;
  logic [AW-1:0] m1 = '0;
  logic [AW-1:0] m2 = '0;

  frame_streamer_if #(.ADDR_W(AW)) bus ();

  frame_streamer #(
    .HRES       (HRES),
    .VRES       (VRES),
    .RD_LATENCY (LAT)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Memory model: data = address, two register stages.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    m1  <= bus.rd_addr_out;
    m2  <= m1;
  end
  assign bus.rd_data_in = 8'(m2);

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.busy_out) busy_cnt++;
    if (bus.frame_done_out) fd_cnt++;
    if (bus.frame_done_out && !bus.data_valid_out) begin
      total++; bad++;
      $display("FAIL frame_done_without_valid: at cycle %0d", cyc);
    end
    if (bus.data_valid_out) begin
      vlog.push_back(cyc);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel: got data=%0d h=%0d v=%0d, none expected",
                 bus.pixel_data_out, bus.hcount_out, bus.vcount_out);
      end else begin
        mon_e = q.pop_front();
        if (bus.pixel_data_out !== mon_e.data) begin
          bad++;
          $display("FAIL pixel_data: got %0d want %0d", bus.pixel_data_out, mon_e.data);
        end
        total++;
        if (bus.hcount_out !== mon_e.h) begin
          bad++;
          $display("FAIL hcount: got %0d want %0d", bus.hcount_out, mon_e.h);
        end
        total++;
        if (bus.vcount_out !== mon_e.v) begin
          bad++;
          $display("FAIL vcount: got %0d want %0d", bus.vcount_out, mon_e.v);
        end
        total++;
        if (bus.frame_done_out !== mon_e.last) begin
          bad++;
          $display("FAIL frame_done: got %0b want %0b", bus.frame_done_out, mon_e.last);
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < int'(NPIX); i++) begin
      e.data = 8'(i);
      e.h    = 11'(i % HRES);
      e.v    = 10'(i / HRES);
      e.last = (i == int'(NPIX) - 1);
      q.push_back(e);
    end
  endtask

  task automatic clear_logs();
    busy_cnt = 0;
    fd_cnt   = 0;
    vlog.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!bus.busy_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.frame_done_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    total += 7;
    if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy_out); end
    if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.data_valid_out); end
    if (bus.frame_done_out !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.frame_done_out); end
    if (bus.rd_addr_out !== '0) begin bad++; $display("FAIL rst_addr: got %0d want 0", bus.rd_addr_out); end
    if (bus.pixel_data_out !== 8'd0) begin bad++; $display("FAIL rst_pixel: got %0d want 0", bus.pixel_data_out); end
    if (bus.hcount_out !== 11'd0) begin bad++; $display("FAIL rst_h: got %0d want 0", bus.hcount_out); end
    if (bus.vcount_out !== 10'd0) begin bad++; $display("FAIL rst_v: got %0d want 0", bus.vcount_out); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_single_frame();
    int unsigned c1;
    bit ok;
    clear_logs();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    c1 = cyc;
    wait_idle(ok);
    total += 7;
    if (!ok) begin bad++; $display("FAIL single_timeout: busy=%b want 0", bus.busy_out); end
    if (vlog.size() != NPIX) begin
      bad++; $display("FAIL single_count: got %0d want %0d", vlog.size(), NPIX);
    end else begin
      if (vlog[0] != c1 + LAT) begin bad++; $display("FAIL single_latency: got %0d want %0d", vlog[0] - c1, LAT); end
      if (vlog[NPIX-1] - vlog[0] != NPIX - 1) begin
        bad++; $display("FAIL single_span: got %0d want %0d", vlog[NPIX-1] - vlog[0], NPIX - 1);
      end
    end
    if (busy_cnt != NPIX + LAT) begin bad++; $display("FAIL single_busy: got %0d want %0d", busy_cnt, NPIX + LAT); end
    if (fd_cnt != 1) begin bad++; $display("FAIL single_done_cnt: got %0d want 1", fd_cnt); end
    if (q.size() != 0) begin bad++; $display("FAIL single_leftover: got %0d want 0", q.size()); end
    if (bus.rd_addr_out !== AW'(NPIX - 1)) begin
      bad++; $display("FAIL single_addr_hold: got %0d want %0d", bus.rd_addr_out, NPIX - 1);
    end
    tick(2);
  endtask

  task automatic test_pause();
    bit ok;
    clear_logs();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    tick(5);
    bus.pause_in = 1'b1;
    tick(3);
    bus.pause_in = 1'b0;
    wait_idle(ok);
    total += 6;
    if (!ok) begin bad++; $display("FAIL pause_timeout: busy=%b want 0", bus.busy_out); end
    if (vlog.size() != NPIX) begin
      bad++; $display("FAIL pause_count: got %0d want %0d", vlog.size(), NPIX);
    end else begin
      if (vlog[4] - vlog[0] != 4) begin bad++; $display("FAIL pause_pre: got %0d want 4", vlog[4] - vlog[0]); end
      if (vlog[5] - vlog[4] != 4) begin bad++; $display("FAIL pause_gap: got %0d want 4", vlog[5] - vlog[4]); end
      if (vlog[NPIX-1] - vlog[5] != NPIX - 6) begin
        bad++; $display("FAIL pause_post: got %0d want %0d", vlog[NPIX-1] - vlog[5], NPIX - 6);
      end
    end
    if (busy_cnt != NPIX + LAT + 3) begin bad++; $display("FAIL pause_busy: got %0d want %0d", busy_cnt, NPIX + LAT + 3); end
    tick(2);
  endtask

  task automatic test_restart_ignored();
    bit ok;
    clear_logs();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    tick(4);
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    wait_done(ok);
    // Start raised in the frame_done cycle must be dropped.
    bus.start_in = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    total += 1;
    if (!ok) begin bad++; $display("FAIL restart_done_timeout: frame_done never seen, want 1"); end
    wait_idle(ok);
    tick(4);
    @(negedge clk);
    total += 5;
    if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL restart_busy_after: got %b want 0", bus.busy_out); end
    if (vlog.size() != NPIX) begin bad++; $display("FAIL restart_count: got %0d want %0d", vlog.size(), NPIX); end
    if (fd_cnt != 1) begin bad++; $display("FAIL restart_done_cnt: got %0d want 1", fd_cnt); end
    if (busy_cnt != NPIX + LAT) begin bad++; $display("FAIL restart_busy: got %0d want %0d", busy_cnt, NPIX + LAT); end
    if (q.size() != 0) begin bad++; $display("FAIL restart_leftover: got %0d want 0", q.size()); end
    tick(1);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    push_frame();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    wait_done(ok);
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    total += 1;
    if (!ok) begin bad++; $display("FAIL b2b_done_timeout: frame_done never seen, want 1"); end
    wait_idle(ok);
    total += 6;
    if (!ok) begin bad++; $display("FAIL b2b_timeout: busy=%b want 0", bus.busy_out); end
    if (vlog.size() != 2 * NPIX) begin
      bad++; $display("FAIL b2b_count: got %0d want %0d", vlog.size(), 2 * NPIX);
    end else begin
      if (vlog[NPIX] - vlog[NPIX-1] != LAT + 2) begin
        bad++; $display("FAIL b2b_gap: got %0d want %0d", vlog[NPIX] - vlog[NPIX-1], LAT + 2);
      end
      if (vlog[2*NPIX-1] - vlog[NPIX] != NPIX - 1) begin
        bad++; $display("FAIL b2b_span: got %0d want %0d", vlog[2*NPIX-1] - vlog[NPIX], NPIX - 1);
      end
    end
    if (fd_cnt != 2) begin bad++; $display("FAIL b2b_done_cnt: got %0d want 2", fd_cnt); end
    if (busy_cnt != 2 * (NPIX + LAT)) begin
      bad++; $display("FAIL b2b_busy: got %0d want %0d", busy_cnt, 2 * (NPIX + LAT));
    end
    tick(2);
  endtask

  task automatic test_reset_midframe();
    int unsigned c1;
    bit ok;
    clear_logs();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    tick(6);
    rst = 1'b1;
    bus.start_in = 1'b1;
    tick(1);
    rst = 1'b0;
    bus.start_in = 1'b0;
    @(negedge clk);
    total += 6;
    if (bus.busy_out !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %b want 0", bus.busy_out); end
    if (bus.data_valid_out !== 1'b0) begin bad++; $display("FAIL mrst_valid: got %b want 0", bus.data_valid_out); end
    if (bus.rd_addr_out !== '0) begin bad++; $display("FAIL mrst_addr: got %0d want 0", bus.rd_addr_out); end
    if (bus.pixel_data_out !== 8'd0) begin bad++; $display("FAIL mrst_pixel: got %0d want 0", bus.pixel_data_out); end
    if (bus.hcount_out !== 11'd0 || bus.vcount_out !== 10'd0) begin
      bad++; $display("FAIL mrst_hv: got %0d,%0d want 0,0", bus.hcount_out, bus.vcount_out);
    end
    if (vlog.size() != 5) begin bad++; $display("FAIL mrst_pre_count: got %0d want 5", vlog.size()); end
    q.delete();
    tick(6);
    total += 2;
    if (vlog.size() != 5) begin bad++; $display("FAIL mrst_quiet: got %0d pixels want 5", vlog.size()); end
    if (fd_cnt != 0) begin bad++; $display("FAIL mrst_done: got %0d want 0", fd_cnt); end
    clear_logs();
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    c1 = cyc;
    wait_idle(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL mrst_timeout: busy=%b want 0", bus.busy_out); end
    if (vlog.size() != NPIX) begin
      bad++; $display("FAIL mrst_count: got %0d want %0d", vlog.size(), NPIX);
    end else if (vlog[0] != c1 + LAT) begin
      bad++; $display("FAIL mrst_latency: got %0d want %0d", vlog[0] - c1, LAT);
    end
    if (fd_cnt != 1) begin bad++; $display("FAIL mrst_done_cnt: got %0d want 1", fd_cnt); end
    if (q.size() != 0) begin bad++; $display("FAIL mrst_leftover: got %0d want 0", q.size()); end
    tick(2);
  endtask

  task automatic test_pause_hold();
    bit ok;
    clear_logs();
    bus.pause_in = 1'b1;
    push_frame();
    bus.start_in = 1'b1;
    tick(1);
    bus.start_in = 1'b0;
    tick(20);
    @(negedge clk);
    total += 3;
    if (bus.busy_out !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", bus.busy_out); end
    if (vlog.size() != 0) begin bad++; $display("FAIL hold_valid: got %0d pixels want 0", vlog.size()); end
    if (bus.rd_addr_out !== '0) begin bad++; $display("FAIL hold_addr: got %0d want 0", bus.rd_addr_out); end
    @(posedge clk); #1;
    bus.pause_in = 1'b0;
    wait_idle(ok);
    total += 4;
    if (!ok) begin bad++; $display("FAIL hold_timeout: busy=%b want 0", bus.busy_out); end
    if (vlog.size() != NPIX) begin
      bad++; $display("FAIL hold_count: got %0d want %0d", vlog.size(), NPIX);
    end else if (vlog[NPIX-1] - vlog[0] != NPIX - 1) begin
      bad++; $display("FAIL hold_span: got %0d want %0d", vlog[NPIX-1] - vlog[0], NPIX - 1);
    end
    if (fd_cnt != 1) begin bad++; $display("FAIL hold_done_cnt: got %0d want 1", fd_cnt); end
    if (q.size() != 0) begin bad++; $display("FAIL hold_leftover: got %0d want 0", q.size()); end
    tick(2);
  endtask

  initial begin
    bus.start_in = 1'b0;
    bus.pause_in = 1'b0;
    test_reset();
    test_single_frame();
    test_pause();
    test_restart_ignored();
    test_back_to_back();
    test_reset_midframe();
    test_pause_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
